// File: rtl/exc_code_pipe_pkg.sv
// Shared ExcCode values and default reset / handler-entry PCs for the exception-code pipeline.
package exc_code_pipe_pkg;

  localparam int CODE_W = 5;
  localparam int PC_W   = 32;

  localparam logic [CODE_W-1:0] EXC_NONE    = 5'd0;
  localparam logic [CODE_W-1:0] EXC_INT     = 5'd0;
  localparam logic [CODE_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [CODE_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [CODE_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [CODE_W-1:0] EXC_RI      = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV      = 5'd12;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [PC_W-1:0] FLUSH_PC = 32'h0000_4180;

endpackage

// File: rtl/exc_code_pipe_if.sv
// Handshake bundle between the pipeline control (master) and the exception-code pipe (slave).
interface exc_code_pipe_if #(
  parameter int STAGES = 3,
  parameter int CODE_W = exc_code_pipe_pkg::CODE_W,
  parameter int PC_W   = exc_code_pipe_pkg::PC_W
);

  logic [CODE_W-1:0]        f_exc_code;
  logic [PC_W-1:0]          f_pc;
  logic                     f_bd;
  logic                     f_valid;
  logic [STAGES*CODE_W-1:0] stage_code;
  logic [STAGES-1:0]        stall;
  logic                     flush;
  logic                     int_req;

  logic [CODE_W-1:0]        exc_code_out;
  logic [PC_W-1:0]          exc_pc_out;
  logic                     exc_bd_out;
  logic                     exc_req;
  logic [STAGES*CODE_W-1:0] stage_code_q;

  modport master (
    output f_exc_code, f_pc, f_bd, f_valid, stage_code, stall, flush, int_req,
    input  exc_code_out, exc_pc_out, exc_bd_out, exc_req, stage_code_q
  );

  modport slave (
    input  f_exc_code, f_pc, f_bd, f_valid, stage_code, stall, flush, int_req,
    output exc_code_out, exc_pc_out, exc_bd_out, exc_req, stage_code_q
  );

endinterface

// File: rtl/exc_code_pipe_stage_reg.sv
// One pipe register {code, pc, bd, valid} plus its older-first code merge; 1-cycle register.
// Update order: reset, flush, own stall (hold), upstream stall (bubble), else load.
module exc_code_pipe_stage_reg
  import exc_code_pipe_pkg::*;
#(
  parameter int               CODE_W   = exc_code_pipe_pkg::CODE_W,
  parameter int               PC_W     = exc_code_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(exc_code_pipe_pkg::RESET_PC),
  parameter logic [PC_W-1:0]  FLUSH_PC = PC_W'(exc_code_pipe_pkg::FLUSH_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              stall_prev,
  input  logic [CODE_W-1:0] in_code,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] local_code,
  output logic [CODE_W-1:0] code_q,
  output logic [PC_W-1:0]   pc_q,
  output logic              bd_q,
  output logic              valid_q,
  output logic [CODE_W-1:0] merged_code
);

  logic [CODE_W-1:0] code_d;
  logic [PC_W-1:0]   pc_d;
  logic              bd_d;
  logic              valid_d;

  always_comb begin
    code_d  = in_code;
    pc_d    = in_pc;
    bd_d    = in_bd;
    valid_d = in_valid;
    if (flush) begin
      code_d  = CODE_W'(EXC_NONE);
      pc_d    = FLUSH_PC;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (stall) begin
      code_d  = code_q;
      pc_d    = pc_q;
      bd_d    = bd_q;
      valid_d = valid_q;
    end else if (stall_prev) begin
      // Bubble keeps the upstream pc/bd so the macroscopic PC stays usable for interrupts.
      code_d  = CODE_W'(EXC_NONE);
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q  <= CODE_W'(EXC_NONE);
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  // Older exception already recorded for this instruction always beats the local one.
  assign merged_code = (code_q != CODE_W'(EXC_NONE)) ? code_q : local_code;

endmodule

// File: rtl/exc_code_pipe.sv
// Exception-code pipe: STAGES registers carry {code, pc, bd, valid}; F code reaches CP0 after
// STAGES cycles, stage codes appear combinationally; stalls hold/bubble, flush clears every register.
module exc_code_pipe
  import exc_code_pipe_pkg::*;
#(
  parameter int               STAGES   = 3,
  parameter int               CODE_W   = exc_code_pipe_pkg::CODE_W,
  parameter int               PC_W     = exc_code_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(exc_code_pipe_pkg::RESET_PC),
  parameter logic [PC_W-1:0]  FLUSH_PC = PC_W'(exc_code_pipe_pkg::FLUSH_PC)
) (
  input logic            clk,
  input logic            reset,
  exc_code_pipe_if.slave bus
);

  logic [STAGES-1:0][CODE_W-1:0] code_q;
  logic [STAGES-1:0][CODE_W-1:0] merged;
  logic [STAGES-1:0][CODE_W-1:0] local_code;
  logic [STAGES-1:0][PC_W-1:0]   pc_q;
  logic [STAGES-1:0]             bd_q;
  logic [STAGES-1:0]             valid_q;

  assign local_code = bus.stage_code;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CODE_W-1:0] in_code;
    logic [PC_W-1:0]   in_pc;
    logic              in_bd;
    logic              in_valid;
    logic              stall_prev;

    if (k == 0) begin : g_head
      assign in_code    = bus.f_exc_code;
      assign in_pc      = bus.f_pc;
      assign in_bd      = bus.f_bd;
      assign in_valid   = bus.f_valid;
      assign stall_prev = 1'b0;
    end else begin : g_tail
      assign in_code    = merged[k-1];
      assign in_pc      = pc_q[k-1];
      assign in_bd      = bd_q[k-1];
      assign in_valid   = valid_q[k-1];
      assign stall_prev = bus.stall[k-1];
    end

    exc_code_pipe_stage_reg #(
      .CODE_W   (CODE_W),
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC),
      .FLUSH_PC (FLUSH_PC)
    ) u_reg (
      .clk         (clk),
      .reset       (reset),
      .flush       (bus.flush),
      .stall       (bus.stall[k]),
      .stall_prev  (stall_prev),
      .in_code     (in_code),
      .in_pc       (in_pc),
      .in_bd       (in_bd),
      .in_valid    (in_valid),
      .local_code  (local_code[k]),
      .code_q      (code_q[k]),
      .pc_q        (pc_q[k]),
      .bd_q        (bd_q[k]),
      .valid_q     (valid_q[k]),
      .merged_code (merged[k])
    );
  end

  logic [CODE_W-1:0] merged_last;
  logic              valid_last;

  assign merged_last = merged[STAGES-1];
  assign valid_last  = valid_q[STAGES-1];

  // Interrupts outrank everything and report code 0 against the current macroscopic PC.
  always_comb begin
    bus.exc_req      = bus.int_req | (valid_last & (merged_last != CODE_W'(EXC_NONE)));
    bus.exc_code_out = CODE_W'(EXC_NONE);
    if (bus.int_req) begin
      bus.exc_code_out = CODE_W'(EXC_INT);
    end else if (valid_last) begin
      bus.exc_code_out = merged_last;
    end
  end

  assign bus.exc_pc_out   = pc_q[STAGES-1];
  assign bus.exc_bd_out   = bd_q[STAGES-1];
  assign bus.stage_code_q = code_q;

endmodule

// File: tb/tb_exc_code_pipe.sv
// Bench for exc_code_pipe: streamed vector table with a scoreboard, then stall/flush/reset sequences.
module tb_exc_code_pipe;
  import exc_code_pipe_pkg::*;

  localparam int S  = 3;
  localparam int CW = 5;
  localparam int PW = 32;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_code_pipe_if #(.STAGES(S), .CODE_W(CW), .PC_W(PW)) bus ();

  exc_code_pipe #(
    .STAGES(S), .CODE_W(CW), .PC_W(PW), .RESET_PC(32'h3000), .FLUSH_PC(32'h4180)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  f;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] pc;
    logic        bd;
    logic        v;
    logic        irq;
    logic [4:0]  x_code;
    logic        x_req;
  } vec_t;

  vec_t vecs[N];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic v);
    bus.f_exc_code = code;
    bus.f_pc       = pc;
    bus.f_bd       = bd;
    bus.f_valid    = v;
  endtask

  function automatic vec_t mk(input logic [4:0] f, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] pc, input logic bd,
                              input logic v, input logic irq, input logic [4:0] xc,
                              input logic xr);
    vec_t r;
    r.f = f; r.s0 = s0; r.s1 = s1; r.s2 = s2; r.pc = pc; r.bd = bd; r.v = v; r.irq = irq;
    r.x_code = xc; r.x_req = xr;
    return r;
  endfunction

  function automatic logic [4:0] sc(input int idx, input int k);
    if (idx < 0 || idx >= N) return 5'd0;
    case (k)
      0:       return vecs[idx].s0;
      1:       return vecs[idx].s1;
      default: return vecs[idx].s2;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    //            f         s0      s1        s2           pc        bd    v     irq   code      req
    vecs[0] = mk(EXC_ADEL, 5'd0,   EXC_OV,   5'd0,        32'h3010, 1'b0, 1'b1, 1'b0, EXC_ADEL, 1'b1);
    vecs[1] = mk(5'd0,     5'd0,   EXC_OV,   5'd0,        32'h3014, 1'b0, 1'b1, 1'b0, EXC_OV,   1'b1);
    vecs[2] = mk(5'd0,     EXC_RI, 5'd0,     EXC_SYSCALL, 32'h3018, 1'b0, 1'b1, 1'b0, EXC_RI,   1'b1);
    vecs[3] = mk(5'd0,     5'd0,   5'd0,     EXC_SYSCALL, 32'h301c, 1'b1, 1'b1, 1'b0, EXC_SYSCALL, 1'b1);
    vecs[4] = mk(5'd0,     5'd0,   5'd0,     5'd0,        32'h3020, 1'b0, 1'b1, 1'b0, 5'd0,     1'b0);
    vecs[5] = mk(EXC_ADES, 5'd0,   5'd0,     5'd0,        32'h3024, 1'b0, 1'b0, 1'b0, 5'd0,     1'b0);
    vecs[6] = mk(5'd0,     5'd0,   5'd0,     EXC_OV,      32'h3028, 1'b0, 1'b1, 1'b1, 5'd0,     1'b1);
    vecs[7] = mk(EXC_SYSCALL, 5'd0, EXC_ADEL, 5'd0,       32'h302c, 1'b1, 1'b1, 1'b0, EXC_SYSCALL, 1'b1);

    reset = 1'b1;
    drive_f(5'd0, 32'h0, 1'b0, 1'b0);
    bus.stage_code = '0;
    bus.stall      = '0;
    bus.flush      = 1'b0;
    bus.int_req    = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_code",  bus.exc_code_out, 0);
    chk("rst_req",   bus.exc_req,      0);
    chk("rst_pc",    bus.exc_pc_out,   32'h3000);
    chk("rst_bd",    bus.exc_bd_out,   0);
    chk("rst_sq",    bus.stage_code_q, 0);
    bus.int_req = 1'b1;
    #1;
    chk("rst_irq_req",  bus.exc_req,      1);
    chk("rst_irq_code", bus.exc_code_out, 0);
    bus.int_req = 1'b0;

    // Stream the table back to back; instruction c sits in register k during iteration c+k+1.
    for (int c = 0; c < N + 3; c++) begin
      if (c < N) begin
        drive_f(vecs[c].f, vecs[c].pc, vecs[c].bd, vecs[c].v);
        sb.push_back(vecs[c]);
      end else begin
        drive_f(5'd0, 32'h3030, 1'b0, 1'b0);
      end
      bus.stage_code = {sc(c - 3, 2), sc(c - 2, 1), sc(c - 1, 0)};
      bus.int_req    = (c >= 3) ? vecs[c-3].irq : 1'b0;
      #1;
      if (c >= 3) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: actual=0 required=entry at iteration %0d", c);
        end else begin
          e = sb.pop_front();
          chk($sformatf("vec%0d_code", c - 3), bus.exc_code_out, e.x_code);
          chk($sformatf("vec%0d_req",  c - 3), bus.exc_req,      e.x_req);
          chk($sformatf("vec%0d_pc",   c - 3), bus.exc_pc_out,   e.pc);
          chk($sformatf("vec%0d_bd",   c - 3), bus.exc_bd_out,   e.bd);
        end
      end
      step();
    end
    chk("sb_drain", sb.size(), 0);

    // Stall reg0 for two cycles with an RI instruction at 0x3020 in D.
    bus.stage_code = '0;
    bus.int_req    = 1'b0;
    bus.stall      = 3'b000;
    drive_f(EXC_RI, 32'h3020, 1'b1, 1'b1);
    step();
    drive_f(5'd0, 32'h3040, 1'b0, 1'b1);
    bus.stall = 3'b001;
    step();
    step();
    chk("stall_sq",   bus.stage_code_q, {5'd0, 5'd0, 5'd10});
    chk("stall_pc",   bus.exc_pc_out,   32'h3020);
    chk("stall_bd",   bus.exc_bd_out,   1);
    chk("stall_req",  bus.exc_req,      0);
    chk("stall_code", bus.exc_code_out, 0);
    bus.int_req = 1'b1;
    #1;
    chk("bub_irq_req",  bus.exc_req,      1);
    chk("bub_irq_code", bus.exc_code_out, 0);
    chk("bub_irq_pc",   bus.exc_pc_out,   32'h3020);
    bus.int_req = 1'b0;
    bus.stall   = 3'b000;
    step();
    chk("release_sq", bus.stage_code_q, {5'd0, 5'd10, 5'd0});
    step();
    chk("release_req",  bus.exc_req,      1);
    chk("release_code", bus.exc_code_out, EXC_RI);
    chk("release_pc",   bus.exc_pc_out,   32'h3020);
    chk("release_bd",   bus.exc_bd_out,   1);
    bus.stall = 3'b100;
    step();
    chk("hold_last_code", bus.exc_code_out, EXC_RI);
    chk("hold_last_pc",   bus.exc_pc_out,   32'h3020);

    // Flush together with a full stall and pending codes everywhere.
    bus.stage_code = {EXC_OV, EXC_OV, EXC_ADES};
    bus.stall      = 3'b111;
    bus.flush      = 1'b1;
    drive_f(EXC_ADEL, 32'h3050, 1'b1, 1'b1);
    step();
    chk("flush_sq",   bus.stage_code_q, 0);
    chk("flush_pc",   bus.exc_pc_out,   32'h4180);
    chk("flush_bd",   bus.exc_bd_out,   0);
    chk("flush_req",  bus.exc_req,      0);
    chk("flush_code", bus.exc_code_out, 0);
    bus.flush      = 1'b0;
    bus.stall      = 3'b000;
    bus.stage_code = '0;

    // Reset in the middle of operation.
    drive_f(EXC_ADEL, 32'h3050, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("pre_rst_req",  bus.exc_req,      1);
    chk("pre_rst_code", bus.exc_code_out, EXC_ADEL);
    chk("pre_rst_pc",   bus.exc_pc_out,   32'h3050);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_pc",   bus.exc_pc_out,   32'h3000);
    chk("mid_rst_sq",   bus.stage_code_q, 0);
    chk("mid_rst_req",  bus.exc_req,      0);
    chk("mid_rst_code", bus.exc_code_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
